// File: rtl/key_arbiter.sv
// key_arbiter: four active-low panel keys sharing one debounce/long-press timer.
// One key at a time owns the counter; the lowest pressed index wins.
module key_arbiter #(
    parameter logic [24:0] CNT_MAX  = 25'd399_999,
    parameter logic [24:0] LONG_MAX = 25'd24_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_in,
    output logic [3:0] key_press,
    output logic [3:0] key_long,
    output logic [1:0] key_id,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_sync1;
    logic [3:0]  r_key_s;
    logic [24:0] r_cnt;
    logic [24:0] w_cnt_nxt;
    logic [1:0]  r_sel;
    logic [1:0]  w_sel_nxt;
    logic        r_long_done;
    logic        w_long_done_nxt;
    logic [3:0]  r_press;
    logic [3:0]  w_press_nxt;
    logic [3:0]  r_long;
    logic [3:0]  w_long_nxt;
    logic [1:0]  w_low_idx;
    logic        w_sel_high;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 4'hF;
            r_key_s <= 4'hF;
        end else begin
            r_sync1 <= key_in;
            r_key_s <= r_sync1;
        end
    end

    // Descending scan so the lowest pressed index is the last writer.
    always_comb begin
        w_low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_key_s[i]) w_low_idx = 2'(i);
        end
    end

    assign w_sel_high = r_key_s[r_sel];

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_sel_nxt       = r_sel;
        w_long_done_nxt = r_long_done;
        w_press_nxt     = 4'b0000;
        w_long_nxt      = 4'b0000;
        case (r_state)
            IDLE: begin
                if (r_key_s != 4'hF) begin
                    w_state_nxt = DEBOUNCE;
                    w_sel_nxt   = w_low_idx;
                    w_cnt_nxt   = '0;
                end
            end
            DEBOUNCE: begin
                if (w_sel_high) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt     = PRESSED;
                    w_cnt_nxt       = '0;
                    w_press_nxt     = 4'b0001 << r_sel;
                    w_long_done_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 25'd1;
                end
            end
            PRESSED: begin
                if (w_sel_high) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LONG_MAX) begin
                    // Counter parks at LONG_MAX so the pulse cannot repeat.
                    if (!r_long_done) begin
                        w_long_nxt      = 4'b0001 << r_sel;
                        w_long_done_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 25'd1;
                end
            end
            RELEASE: begin
                if (!w_sel_high) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 25'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_sel       <= 2'd0;
            r_long_done <= 1'b0;
            r_press     <= 4'b0000;
            r_long      <= 4'b0000;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sel       <= w_sel_nxt;
            r_long_done <= w_long_done_nxt;
            r_press     <= w_press_nxt;
            r_long      <= w_long_nxt;
        end
    end

    assign key_press = r_press;
    assign key_long  = r_long;
    assign key_id    = r_sel;
    assign busy      = (r_state != IDLE);

endmodule
